axi_register: RTL and testbench
===============================

// Module: axi_register
// PURPOSE
//   Single-entry AXI4-Stream register slice: one pipeline stage between an
//   upstream AXIS master and a downstream AXIS slave. Captures one beat
//   (tdata + tlast) and holds it until the downstream side accepts it.
//   Sits on streaming datapaths to break timing on tvalid/tdata/tlast.
// PARAMETERS
//   DATA_WIDTH  8  width of s_axis_tdata / m_axis_tdata in bits
// PORTS
//   aclk           in   1           clock; all state updates on rising edge
//   aresetn        in   1           async reset, ACTIVE-HIGH (1 = reset)
//   s_axis_tdata   in   DATA_WIDTH  upstream data
//   s_axis_tvalid  in   1           upstream beat valid
//   s_axis_tlast   in   1           upstream end-of-packet marker
//   s_axis_tready  out  1           slice can accept a beat this cycle
//   m_axis_tdata   out  DATA_WIDTH  stored data
//   m_axis_tvalid  out  1           stored beat present
//   m_axis_tlast   out  1           stored tlast
//   m_axis_tready  in   1           downstream accepts beat
// BEHAVIOUR
//   - One clock (aclk); reset is asynchronous and active-high.
//   - Reset (aresetn=1, async assert): m_axis_tvalid=0, m_axis_tdata=0,
//     m_axis_tlast=0; the slice is empty. s_axis_tready=1 during and after
//     reset. Deassertion takes effect at the next rising edge.
//   - Handshakes: write = s_axis_tvalid & s_axis_tready;
//     read = m_axis_tvalid & m_axis_tready.
//   - s_axis_tready = ~m_axis_tvalid | m_axis_tready (combinational).
//     High when empty, or when full and the beat is drained this cycle.
//   - Write: at the edge, m_axis_tdata <= s_axis_tdata,
//     m_axis_tlast <= s_axis_tlast, m_axis_tvalid <= 1.
//     Latency is 1 cycle from input handshake to m_axis_tvalid.
//   - Read without write: m_axis_tvalid <= 0. tdata and tlast hold their
//     last values; they are don't-care while m_axis_tvalid=0.
//   - Read and write in the same cycle: the new beat replaces the old one,
//     m_axis_tvalid stays 1, and throughput is 1 beat/cycle.
//   - Full with m_axis_tready=0: s_axis_tready=0. m_axis_tdata,
//     m_axis_tlast and m_axis_tvalid are stable. Input changes are ignored.
//   - s_axis_tdata/s_axis_tlast are sampled only on a write.
//     s_axis_tlast is carried with its beat and never altered.
//   - m_axis_tvalid never drops without a read (AXIS rule).
//   - Reset mid-transfer discards the held beat immediately.
//   - Two states, EMPTY (m_axis_tvalid=0) and FULL:
//     EMPTY -write-> FULL; FULL -read & ~write-> EMPTY;
//     FULL -read & write-> FULL (reload).
// STRUCTURE
//   - Flat module, no sub-modules. Data and tlast registers have no reset
//     dependency on tvalid beyond the reset clear above.
//   - Shared package (axis_pkg): DATA_WIDTH default constant, and a beat
//     typedef { logic [DATA_WIDTH-1:0] data; logic last; }.
// TESTING
//   1 Reset: aresetn=1 for 10 ns -> m_axis_tvalid=0, m_axis_tdata=0,
//     m_axis_tlast=0, s_axis_tready=1.
//   2 Write to empty: s_axis_tvalid=1, data=0x24, tlast=0, m_axis_tready=0
//     -> next edge: m_axis_tvalid=1, m_axis_tdata=0x24, s_axis_tready=0.
//   3 Backpressure: hold m_axis_tready=0, change s_axis_tdata to 0x81 for
//     3 cycles -> m_axis_tdata stays 0x24, m_axis_tvalid stays 1.
//   4 Drain: s_axis_tvalid=0, m_axis_tready=1 -> one read; next edge
//     m_axis_tvalid=0, s_axis_tready=1.
//   5 Simultaneous: full with 0x09, s_axis_tvalid=1, data=0x63, tlast=1,
//     m_axis_tready=1 -> s_axis_tready=1; next edge m_axis_tdata=0x63,
//     m_axis_tlast=1, m_axis_tvalid=1.
//   6 Streaming plus reset: 8 back-to-back beats 0x00..0x07 with
//     m_axis_tready=1 -> output is same order, 1-cycle lag, tlast kept;
//     aresetn=1 mid-stream -> m_axis_tvalid=0 at once.

Source files
------------

// File: rtl/axis_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkg
//   Shared AXI4-Stream definitions for the streaming datapath blocks.
//   - AXIS_DATA_WIDTH : default tdata width, in bits
//   - axis_beat_t     : one stream beat (data + end-of-packet marker) at the
//                       default width
//   - slice_state_t   : occupancy state of a single-entry register slice
//   - axis_beat_make  : helper that packs tdata/tlast into an axis_beat_t
// ---------------------------------------------------------------------------
package axis_pkg;

    localparam int AXIS_DATA_WIDTH = 8;

    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0] data;
        logic                       last;
    } axis_beat_t;

    // EMPTY means no beat is held (m_axis_tvalid=0); FULL means one beat is
    // waiting for the downstream handshake.
    typedef enum logic {
        SLICE_EMPTY = 1'b0,
        SLICE_FULL  = 1'b1
    } slice_state_t;

    function automatic axis_beat_t axis_beat_make(
        input logic [AXIS_DATA_WIDTH-1:0] data,
        input logic                       last
    );
        axis_beat_t beat;
        beat.data = data;
        beat.last = last;
        return beat;
    endfunction

endpackage : axis_pkg

// File: rtl/axi_register.sv
// ---------------------------------------------------------------------------
// axi_register
//   Single-entry AXI4-Stream register slice. Adds one pipeline stage between
//   an upstream AXIS master and a downstream AXIS slave, registering
//   tvalid/tdata/tlast to break timing paths. Sustains one beat per cycle
//   when the downstream side is always ready.
//
// Parameters
//   DATA_WIDTH     width of s_axis_tdata / m_axis_tdata
//
// Ports
//   aclk           clock, all state updates on the rising edge
//   aresetn        asynchronous reset, ACTIVE-HIGH despite its name
//   s_axis_tdata   upstream data
//   s_axis_tvalid  upstream beat valid
//   s_axis_tlast   upstream end-of-packet marker
//   s_axis_tready  slice can accept a beat this cycle (combinational)
//   m_axis_tdata   stored data
//   m_axis_tvalid  stored beat present
//   m_axis_tlast   stored end-of-packet marker
//   m_axis_tready  downstream accepts the stored beat
// ---------------------------------------------------------------------------
module axi_register
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);

    // Beat storage sized by this instance's DATA_WIDTH (the package typedef
    // is fixed at the default width).
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } beat_t;

    slice_state_t state_q;
    slice_state_t state_d;
    beat_t        beat_q;

    logic wr_en;
    logic rd_en;

    // Ready looks through to the downstream ready so a full slice can be
    // drained and reloaded in the same cycle, giving full throughput.
    assign s_axis_tready = (state_q == SLICE_EMPTY) | m_axis_tready;

    assign wr_en = s_axis_tvalid & s_axis_tready;
    assign rd_en = m_axis_tvalid & m_axis_tready;

    // ---- occupancy state register ----
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            state_q <= SLICE_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLICE_EMPTY: begin
                if (wr_en) begin
                    state_d = SLICE_FULL;
                end
            end
            SLICE_FULL: begin
                // A simultaneous read and write reloads and stays FULL.
                if (rd_en && !wr_en) begin
                    state_d = SLICE_EMPTY;
                end
            end
            default: begin
                state_d = SLICE_EMPTY;
            end
        endcase
    end

    // ---- beat storage ----
    // Loads only on an input handshake; holds its value after a read since
    // the contents are don't-care while m_axis_tvalid is low.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            beat_q <= '0;
        end else if (wr_en) begin
            beat_q.data <= s_axis_tdata;
            beat_q.last <= s_axis_tlast;
        end
    end

    assign m_axis_tvalid = (state_q == SLICE_FULL);
    assign m_axis_tdata  = beat_q.data;
    assign m_axis_tlast  = beat_q.last;

endmodule : axi_register

// File: tb/tb_axi_register.sv
// ---------------------------------------------------------------------------
// tb_axi_register
//   Directed self-checking bench for the axi_register AXIS slice.
//   Inputs change 1 ns after a rising edge; outputs are sampled at that
//   point as well, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_axi_register;

    localparam int DW = 8;

    logic          aclk;
    logic          aresetn;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;

    int errors;
    int checks;

    axi_register #(.DATA_WIDTH(DW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn       = 1'b1;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        #10;
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            errors++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid);
        end
        checks++;
        if (m_axis_tdata !== 8'h00) begin
            errors++; $display("FAIL reset_tdata: got %h expected 00", m_axis_tdata);
        end
        checks++;
        if (m_axis_tlast !== 1'b0) begin
            errors++; $display("FAIL reset_tlast: got %b expected 0", m_axis_tlast);
        end
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL reset_tready: got %b expected 1", s_axis_tready);
        end
        step();
        aresetn = 1'b0;
        step();
        checks++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: tready=%b tvalid=%b expected 1/0",
                     s_axis_tready, m_axis_tvalid);
        end
    endtask

    task automatic test_write_empty();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h24;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        step();
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
            errors++; $display("FAIL write_tvalid: got %b expected 1", m_axis_tvalid);
        end
        checks++;
        if (m_axis_tdata !== 8'h24) begin
            errors++; $display("FAIL write_tdata: got %h expected 24", m_axis_tdata);
        end
        checks++;
        if (m_axis_tlast !== 1'b0) begin
            errors++; $display("FAIL write_tlast: got %b expected 0", m_axis_tlast);
        end
        checks++;
        if (s_axis_tready !== 1'b0) begin
            errors++; $display("FAIL write_full_tready: got %b expected 0", s_axis_tready);
        end
    endtask

    task automatic test_backpressure();
        s_axis_tdata  = 8'h81;
        s_axis_tlast  = 1'b1;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (m_axis_tdata !== 8'h24 || m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: data=%h valid=%b last=%b expected 24/1/0",
                         i, m_axis_tdata, m_axis_tvalid, m_axis_tlast);
            end
            checks++;
            if (s_axis_tready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_tready[%0d]: got %b expected 0", i, s_axis_tready);
            end
        end
    endtask

    task automatic test_drain();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        #1;
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL drain_passthru_tready: got %b expected 1", s_axis_tready);
        end
        step();
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            errors++; $display("FAIL drain_tvalid: got %b expected 0", m_axis_tvalid);
        end
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL drain_tready: got %b expected 1", s_axis_tready);
        end
        // Stays empty with nothing offered.
        m_axis_tready = 1'b0;
        step();
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL empty_idle: tvalid=%b tready=%b expected 0/1",
                     m_axis_tvalid, s_axis_tready);
        end
    endtask

    task automatic test_simultaneous();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h09;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        step();
        checks++;
        if (m_axis_tdata !== 8'h09 || m_axis_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL sim_preload: data=%h valid=%b expected 09/1", m_axis_tdata, m_axis_tvalid);
        end
        s_axis_tdata  = 8'h63;
        s_axis_tlast  = 1'b1;
        m_axis_tready = 1'b1;
        #1;
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL sim_tready: got %b expected 1", s_axis_tready);
        end
        step();
        checks++;
        if (m_axis_tdata !== 8'h63) begin
            errors++; $display("FAIL sim_tdata: got %h expected 63", m_axis_tdata);
        end
        checks++;
        if (m_axis_tlast !== 1'b1) begin
            errors++; $display("FAIL sim_tlast: got %b expected 1", m_axis_tlast);
        end
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
            errors++; $display("FAIL sim_tvalid: got %b expected 1", m_axis_tvalid);
        end
        s_axis_tvalid = 1'b0;
        step();
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            errors++; $display("FAIL sim_drain_tvalid: got %b expected 0", m_axis_tvalid);
        end
    endtask

    task automatic test_back_to_back_reset();
        logic [DW-1:0] exp_data;
        logic          exp_last;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DW'(i);
            s_axis_tlast  = (i == 7);
            step();
            exp_data = DW'(i);
            exp_last = (i == 7);
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_data || m_axis_tlast !== exp_last) begin
                errors++;
                $display("FAIL stream_beat[%0d]: valid=%b data=%h last=%b expected 1/%h/%b",
                         i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, exp_data, exp_last);
            end
            checks++;
            if (s_axis_tready !== 1'b1) begin
                errors++; $display("FAIL stream_tready[%0d]: got %b expected 1", i, s_axis_tready);
            end
        end
        // Second burst, interrupted by reset away from any clock edge.
        for (int i = 0; i < 3; i++) begin
            s_axis_tdata = DW'(8'hA0 + i);
            s_axis_tlast = 1'b1;
            step();
        end
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hA2) begin
            errors++;
            $display("FAIL midstream_pre_reset: valid=%b data=%h expected 1/a2", m_axis_tvalid, m_axis_tdata);
        end
        #2;
        aresetn = 1'b1;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00 || m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL midstream_reset: valid=%b data=%h last=%b expected 0/00/0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL midstream_reset_tready: got %b expected 1", s_axis_tready);
        end
        s_axis_tvalid = 1'b0;
        step();
        aresetn = 1'b0;
        step();
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            errors++; $display("FAIL after_reset_tvalid: got %b expected 0", m_axis_tvalid);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_write_empty();
        test_backpressure();
        test_drain();
        test_simultaneous();
        test_back_to_back_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_axi_register
